// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_capture
//  Description : Receive-side monitor for a multiplexed 4-digit, active-low
//                7-segment display (an/seg). Decodes each stable digit
//                activation back to a hex nibble or dash and rebuilds the
//                displayed 16-bit value once all four positions are seen.
//  Ports       : clk         - system clock (display driver domain)
//                rst_n       - asynchronous active-low reset
//                an[3:0]     - digit enables, active-low, bit0 = LS digit
//                seg[6:0]    - segment pattern, active-low
//                clr_err     - synchronous clear of sticky error flags
//                digits      - last complete frame, digit i in [4i+3:4i]
//                is_number   - 1 = last frame was hex digits, 0 = dashes
//                frame_vld   - one-cycle pulse when digits/is_number update
//                digit_seen  - positions captured in the pending frame
//                code_err    - sticky: bad pattern or dash/digit mix
//                an_err      - sticky: more than one an bit low at once
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        clr_err,
    output logic [15:0] digits,
    output logic        is_number,
    output logic        frame_vld,
    output logic [3:0]  digit_seen,
    output logic        code_err,
    output logic        an_err
);

    // Counter value just before the capture point: the increment that takes
    // the counter to STABLE_CYCLES-1 is the capture cycle.
    localparam logic [15:0] C_CAP_CNT = 16'(STABLE_CYCLES - 2);
    localparam logic [15:0] C_CNT_MAX = 16'hffff;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [3:0]  r_a_q;        // registered an
    logic [6:0]  r_s_q;        // registered seg
    logic [3:0]  r_a_p;        // previous r_a_q
    logic [6:0]  r_s_p;        // previous r_s_q
    logic [15:0] r_cnt;        // stability counter
    logic [15:0] r_pend_nib;   // pending frame nibbles
    logic [3:0]  r_pend_dash;  // pending frame dash flags
    logic [3:0]  r_seen;       // positions captured in pending frame
    logic        r_done;       // pending frame complete, commit next cycle
    logic [15:0] r_digits;
    logic        r_is_number;
    logic        r_frame_vld;
    logic        r_code_err;
    logic        r_an_err;

    // ------------------------------------------------------------------
    // Combinational decisions on the registered pin samples
    // ------------------------------------------------------------------
    logic [2:0]  w_low_cnt;
    logic        w_single;
    logic        w_multi;
    logic        w_same;
    logic        w_inc;
    logic        w_hit;
    logic [3:0]  w_pos;
    logic [3:0]  w_nib;
    logic        w_dash;
    logic        w_valid;
    logic        w_capture;
    logic        w_bad_code;
    logic        w_mixed;
    logic [3:0]  w_seen_base;
    logic [3:0]  w_seen_next;

    assign w_low_cnt = 3'($countones(~r_a_q));
    assign w_single  = (w_low_cnt == 3'd1);
    assign w_multi   = (w_low_cnt >= 3'd2);
    assign w_same    = ({r_a_q, r_s_q} == {r_a_p, r_s_p});
    assign w_inc     = w_single && w_same;
    // Only the increment out of C_CAP_CNT fires, so a long hold captures once.
    assign w_hit     = w_inc && (r_cnt == C_CAP_CNT);
    assign w_pos     = ~r_a_q;

    always_comb begin
        w_nib   = 4'h0;
        w_dash  = 1'b0;
        w_valid = 1'b1;
        case (r_s_q)
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'ha;
            7'h03:   w_nib = 4'hb;
            7'h46:   w_nib = 4'hc;
            7'h21:   w_nib = 4'hd;
            7'h06:   w_nib = 4'he;
            7'h0e:   w_nib = 4'hf;
            7'h3f:   w_dash = 1'b1;
            default: w_valid = 1'b0;
        endcase
    end

    assign w_capture  = w_hit && w_valid;
    assign w_bad_code = w_hit && !w_valid;
    // A frame that is neither all-dash nor dash-free is inconsistent.
    assign w_mixed    = r_done && (r_pend_dash != 4'h0) && (r_pend_dash != 4'hf);

    // On the commit cycle the pending frame restarts from empty.
    assign w_seen_base = r_done ? 4'h0 : r_seen;
    assign w_seen_next = w_capture ? (w_seen_base | w_pos) : w_seen_base;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q       <= 4'hf;
            r_s_q       <= 7'h7f;
            r_a_p       <= 4'hf;
            r_s_p       <= 7'h7f;
            r_cnt       <= 16'h0000;
            r_pend_nib  <= 16'h0000;
            r_pend_dash <= 4'h0;
            r_seen      <= 4'h0;
            r_done      <= 1'b0;
            r_digits    <= 16'h0000;
            r_is_number <= 1'b0;
            r_frame_vld <= 1'b0;
            r_code_err  <= 1'b0;
            r_an_err    <= 1'b0;
        end else begin
            r_a_q <= an;
            r_s_q <= seg;
            r_a_p <= r_a_q;
            r_s_p <= r_s_q;

            if (w_inc) begin
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= 16'h0000;
            end

            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_pos[i]) begin
                        r_pend_nib[4*i +: 4] <= w_nib;
                        r_pend_dash[i]       <= w_dash;
                    end
                end
            end

            r_seen      <= (w_capture && (w_seen_next == 4'hf)) ? 4'hf : w_seen_next;
            r_done      <= w_capture && (w_seen_next == 4'hf);
            r_frame_vld <= r_done;

            if (r_done) begin
                r_digits    <= r_pend_nib;
                r_is_number <= (r_pend_dash == 4'h0);
            end

            // Clear first, then OR in new errors so a same-cycle error wins.
            r_code_err <= (r_code_err & ~clr_err) | w_bad_code | w_mixed;
            r_an_err   <= (r_an_err & ~clr_err) | w_multi;
        end
    end

    assign digits     = r_digits;
    assign is_number  = r_is_number;
    assign frame_vld  = r_frame_vld;
    assign digit_seen = r_seen;
    assign code_err   = r_code_err;
    assign an_err     = r_an_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_capture
//  Description : Directed self-checking bench for seg_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_capture;

    localparam int STABLE_CYCLES = 16;
    localparam int HOLD          = 40;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clr_err;
    logic [15:0] digits;
    logic        is_number;
    logic        frame_vld;
    logic [3:0]  digit_seen;
    logic        code_err;
    logic        an_err;

    int n_checks;
    int n_pass;
    int n_vld;

    seg_capture #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .clr_err    (clr_err),
        .digits     (digits),
        .is_number  (is_number),
        .frame_vld  (frame_vld),
        .digit_seen (digit_seen),
        .code_err   (code_err),
        .an_err     (an_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive pins, advance one clock, sample 1 time unit after the edge.
    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic c);
        an      = a;
        seg     = s;
        clr_err = c;
        @(posedge clk);
        #1;
        if (frame_vld === 1'b1) n_vld++;
    endtask

    task automatic blank(input int n);
        repeat (n) step(4'hf, 7'h7f, 1'b0);
    endtask

    // Driver-style scan; segs holds the pattern for position p in [7p+6:7p].
    task automatic scan(input logic [27:0] segs);
        logic [3:0] a;
        for (int p = 0; p < 4; p++) begin
            a = ~(4'd1 << p);
            repeat (HOLD) step(a, segs[7*p +: 7], 1'b0);
            blank(4);
        end
        blank(4);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_vld    = 0;
        rst_n    = 1'b0;
        an       = 4'hf;
        seg      = 7'h7f;
        clr_err  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits",    32'(digits),     32'h0);
        check("rst_is_number", 32'(is_number),  32'h0);
        check("rst_frame_vld", 32'(frame_vld),  32'h0);
        check("rst_seen",      32'(digit_seen), 32'h0);
        check("rst_code_err",  32'(code_err),   32'h0);
        check("rst_an_err",    32'(an_err),     32'h0);
        rst_n = 1'b1;
        blank(2);

        // 1: 0x1A2F -> pos0 F, pos1 2, pos2 A, pos3 1
        n_vld = 0;
        scan({7'h79, 7'h08, 7'h24, 7'h0e});
        check("t1_vld_pulses", 32'(n_vld),     32'd1);
        check("t1_digits",     32'(digits),    32'h1A2F);
        check("t1_is_number",  32'(is_number), 32'h1);
        check("t1_code_err",   32'(code_err),  32'h0);
        check("t1_an_err",     32'(an_err),    32'h0);
        check("t1_seen_clr",   32'(digit_seen), 32'h0);

        // 2: all dashes
        n_vld = 0;
        scan({7'h3f, 7'h3f, 7'h3f, 7'h3f});
        check("t2_vld_pulses", 32'(n_vld),     32'd1);
        check("t2_digits",     32'(digits),    32'h0000);
        check("t2_is_number",  32'(is_number), 32'h0);
        check("t2_code_err",   32'(code_err),  32'h0);

        // 3: one sample short of stable, then exactly stable
        repeat (STABLE_CYCLES - 1) step(4'b1110, 7'h40, 1'b0);
        blank(4);
        check("t3_short_seen", 32'(digit_seen), 32'h0);
        repeat (STABLE_CYCLES) step(4'b1110, 7'h40, 1'b0);
        blank(4);
        check("t3_exact_seen", 32'(digit_seen), 32'h1);

        // 4: undecodable pattern on position 2
        repeat (HOLD) step(4'b1011, 7'h7e, 1'b0);
        blank(4);
        check("t4_code_err",   32'(code_err),   32'h1);
        check("t4_seen",       32'(digit_seen), 32'h1);
        step(4'hf, 7'h7f, 1'b1);
        check("t4_clr",        32'(code_err),   32'h0);
        blank(2);
        check("t4_stays_clr",  32'(code_err),   32'h0);

        // 5: two enables low
        repeat (3) step(4'b1100, 7'h40, 1'b0);
        check("t5_an_err",     32'(an_err),     32'h1);
        check("t5_seen",       32'(digit_seen), 32'h1);
        step(4'b1100, 7'h40, 1'b1);
        check("t5_err_wins",   32'(an_err),     32'h1);
        blank(2);
        step(4'hf, 7'h7f, 1'b1);
        check("t5_clr",        32'(an_err),     32'h0);
        blank(2);

        // Mixed frame: pos0 7, pos1 8, pos2 C, pos3 dash
        n_vld = 0;
        scan({7'h3f, 7'h46, 7'h00, 7'h78});
        check("mix_vld_pulses", 32'(n_vld),     32'd1);
        check("mix_digits",     32'(digits),    32'h0C87);
        check("mix_is_number",  32'(is_number), 32'h0);
        check("mix_code_err",   32'(code_err),  32'h1);
        step(4'hf, 7'h7f, 1'b1);
        blank(2);

        // 0x5BE7 -> pos0 7, pos1 E, pos2 B, pos3 5
        n_vld = 0;
        scan({7'h12, 7'h03, 7'h06, 7'h78});
        check("p2_vld_pulses", 32'(n_vld),     32'd1);
        check("p2_digits",     32'(digits),    32'h5BE7);
        check("p2_is_number",  32'(is_number), 32'h1);
        check("p2_code_err",   32'(code_err),  32'h0);

        // 6: reset in the middle of the fourth position
        repeat (HOLD) step(4'b1110, 7'h79, 1'b0);
        blank(4);
        repeat (HOLD) step(4'b1101, 7'h79, 1'b0);
        blank(4);
        repeat (HOLD) step(4'b1011, 7'h79, 1'b0);
        blank(4);
        check("t6_pre_seen", 32'(digit_seen), 32'h7);
        repeat (8) step(4'b0111, 7'h79, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_digits",    32'(digits),     32'h0);
        check("t6_is_number", 32'(is_number),  32'h0);
        check("t6_vld",       32'(frame_vld),  32'h0);
        check("t6_seen",      32'(digit_seen), 32'h0);
        check("t6_errs",      32'({code_err, an_err}), 32'h0);
        @(posedge clk);
        #1;
        an    = 4'hf;
        seg   = 7'h7f;
        rst_n = 1'b1;
        blank(2);
        n_vld = 0;
        scan({7'h40, 7'h40, 7'h40, 7'h10});
        check("t6_vld_pulses", 32'(n_vld),     32'd1);
        check("t6_new_digits", 32'(digits),    32'h0009);
        check("t6_new_number", 32'(is_number), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
